// File: rtl/ndma_pkg.sv
// NanoDMA shared types: read-engine state encoding and bus geometry helper.
package ndma_pkg;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_ISSUE = 2'd1,
      RD_DRAIN = 2'd2
   } ndma_rd_state_e;

   // Bytes carried by one bus beat; also the address increment between words.
   function automatic int unsigned beat_bytes(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ndma_credit_ctr.sv
// NanoDMA outstanding-read counter: up/down, saturating at 0 and MaxCount.
// A simultaneous increment and decrement leaves the count unchanged.
module ndma_credit_ctr #(
   parameter int unsigned MaxCount = 2,
   parameter int unsigned CntBits  = $clog2(MaxCount + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               inc_i,
   input  logic               dec_i,
   output logic [CntBits-1:0] count_o,
   output logic               at_max_o
);

   logic [CntBits-1:0] count_q;
   logic [CntBits-1:0] count_d;

   // Next count: only a lone inc or lone dec moves it, never past the limits.
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != CntBits'(MaxCount))) begin
         count_d = count_q + CntBits'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - CntBits'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign at_max_o = (count_q == CntBits'(MaxCount));

endmodule

// File: rtl/ndma_obi_reader.sv
// NanoDMA read engine: issues OBI word reads from a programmed source address
// and pushes the returned words into the data FIFO, gated by FIFO free space.
// Optional build macro NDMA_RD_ERR_ABORT_EN: on an error response stop issuing,
// discard remaining beats, then finish with done_o/err_o. Without it the
// transfer always runs to completion and err_o reports any erred beat.
module ndma_obi_reader
   import ndma_pkg::*;
#(
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned MaxTxSize      = 256,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned FifoDepth      = 4,
   parameter int unsigned TxCntBits      = $clog2(MaxTxSize + 1),
   parameter int unsigned OutBits        = $clog2(MaxOutstanding + 1),
   parameter int unsigned FreeBits       = $clog2(FifoDepth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [AddrWidth-1:0]   src_addr_i,
   input  logic [TxCntBits-1:0]   len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   obi_req_o,
   input  logic                   obi_gnt_i,
   output logic [AddrWidth-1:0]   obi_addr_o,
   output logic                   obi_we_o,
   output logic [DataWidth/8-1:0] obi_be_o,
   input  logic                   obi_rvalid_i,
   input  logic [DataWidth-1:0]   obi_rdata_i,
   input  logic                   obi_err_i,
   input  logic [FreeBits-1:0]    fifo_free_i,
   output logic                   push_o,
   output logic [DataWidth-1:0]   data_o
);

   localparam int unsigned         BeatBytes   = beat_bytes(DataWidth);
   localparam logic [AddrWidth-1:0] AddrStep    = AddrWidth'(BeatBytes);
   localparam logic [AddrWidth-1:0] AddrLowMask = AddrWidth'(BeatBytes - 1);
`ifdef NDMA_RD_ERR_ABORT_EN
   localparam bit AbortEn = 1'b1;
`else
   localparam bit AbortEn = 1'b0;
`endif

   ndma_rd_state_e         state_q, state_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [TxCntBits-1:0]   remaining_q, remaining_d;
   logic                   req_hold_q, req_hold_d;
   logic                   err_q, err_d;
   logic                   zero_done_q, zero_done_d;
   logic                   push_q, push_d;
   logic [DataWidth-1:0]   data_q, data_d;

   logic [OutBits-1:0]     out_cnt;
   logic                   out_at_max;
   logic                   rsp_valid;
   logic                   abort_now;
   logic                   credit_ok;
   logic                   req;
   logic                   hs;
   logic                   fsm_done;
   logic                   fsm_busy;

   // Granted-but-unanswered reads; a grant and a response in one cycle cancel.
   ndma_credit_ctr #(
      .MaxCount (MaxOutstanding),
      .CntBits  (OutBits)
   ) u_credit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (hs),
      .dec_i    (rsp_valid),
      .count_o  (out_cnt),
      .at_max_o (out_at_max)
   );

   // Request gating, response capture and the IDLE/ISSUE/DRAIN sequencer.
   always_comb begin
      // Responses with nothing outstanding (e.g. stragglers after reset) are dropped.
      rsp_valid = obi_rvalid_i && (out_cnt != '0);
      abort_now = AbortEn && (err_q || (rsp_valid && obi_err_i));
      // Every in-flight beat plus the word being pushed now needs a FIFO slot,
      // since fifo_free_i only reflects a push one cycle later.
      credit_ok = (32'(out_cnt) + 32'(push_q)) < 32'(fifo_free_i);
      // A raised request is held until granted, whatever the gating does meanwhile.
      req       = (state_q == RD_ISSUE) &&
                  (req_hold_q ||
                   ((remaining_q != '0) && !out_at_max && credit_ok && !abort_now));
      hs        = req && obi_gnt_i;

      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      req_hold_d  = req_hold_q;
      err_d       = err_q || (rsp_valid && obi_err_i);
      zero_done_d = 1'b0;
      push_d      = rsp_valid && !abort_now;
      data_d      = rsp_valid ? obi_rdata_i : data_q;
      fsm_done    = 1'b0;
      fsm_busy    = 1'b0;

      case (state_q)
         RD_IDLE: begin
            if (start_i) begin
               err_d      = 1'b0;
               req_hold_d = 1'b0;
               if (len_i != '0) begin
                  addr_d      = src_addr_i & ~AddrLowMask;
                  remaining_d = len_i;
                  state_d     = RD_ISSUE;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            fsm_busy   = 1'b1;
            req_hold_d = req && !obi_gnt_i;
            if (hs) begin
               addr_d      = addr_q + AddrStep;
               remaining_d = remaining_q - TxCntBits'(1);
            end
            if ((hs && (remaining_q == TxCntBits'(1))) ||
                (abort_now && (!req || obi_gnt_i))) begin
               req_hold_d = 1'b0;
               state_d    = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if ((out_cnt == '0) && !push_q) begin
               fsm_done = 1'b1;
               state_d  = RD_IDLE;
            end else begin
               fsm_busy = 1'b1;
            end
         end
         default: begin
            state_d = RD_IDLE;
         end
      endcase
   end

   // State, address/length tracking and the registered FIFO write port.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RD_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         req_hold_q  <= 1'b0;
         err_q       <= 1'b0;
         zero_done_q <= 1'b0;
         push_q      <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         req_hold_q  <= req_hold_d;
         err_q       <= err_d;
         zero_done_q <= zero_done_d;
         push_q      <= push_d;
         data_q      <= data_d;
      end
   end

   assign busy_o     = fsm_busy;
   assign done_o     = fsm_done || zero_done_q;
   assign err_o      = fsm_done && err_q;
   assign obi_req_o  = req;
   assign obi_addr_o = addr_q;
   assign obi_we_o   = 1'b0;
   assign obi_be_o   = '1;
   assign push_o     = push_q;
   assign data_o     = data_q;

endmodule

// File: tb/tb_ndma_obi_reader.sv
// Directed bench for ndma_obi_reader with an in-order OBI responder and a
// scoreboard of expected grant addresses and FIFO words.
module tb_ndma_obi_reader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [8:0]  len;
   logic        busy_o, done_o, err_o;
   logic        obi_req_o;
   logic        obi_gnt_i;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic        obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        obi_err_i;
   logic [2:0]  fifo_free_i;
   logic        push_o;
   logic [31:0] data_o;

   ndma_obi_reader dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .src_addr_i   (src_addr),
      .len_i        (len),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .obi_req_o    (obi_req_o),
      .obi_gnt_i    (obi_gnt_i),
      .obi_addr_o   (obi_addr_o),
      .obi_we_o     (obi_we_o),
      .obi_be_o     (obi_be_o),
      .obi_rvalid_i (obi_rvalid_i),
      .obi_rdata_i  (obi_rdata_i),
      .obi_err_i    (obi_err_i),
      .fifo_free_i  (fifo_free_i),
      .push_o       (push_o),
      .data_o       (data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] pend_q[$];
   logic [31:0] err_addr     = 32'h0;
   bit          err_addr_en  = 1'b0;
   bit          rsp_en       = 1'b1;

   int          n_grants      = 0;
   int          n_push        = 0;
   int          done_cnt      = 0;
   int          done_cyc      = 0;
   int          first_gnt_cyc = -1;
   int          inflight      = 0;
   int          max_inflight  = 0;
   bit          last_err      = 1'b0;
   bit          busy_at_done  = 1'b0;
   logic [31:0] last_gnt_addr = 32'h0;
   bit          prev_req      = 1'b0;
   bit          prev_gnt      = 1'b0;
   logic [31:0] prev_addr     = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: grants, hold stability, pushes and completion, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_req && !prev_gnt)
            chk("req_hold_stable", {31'b0, obi_req_o, obi_addr_o}, {31'b0, 1'b1, prev_addr});
         if (obi_req_o && obi_gnt_i) begin
            n_grants++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            last_gnt_addr = obi_addr_o;
            pend_q.push_back(obi_addr_o);
            inflight++;
            if (exp_addr_q.size() > 0) chk("grant_addr", obi_addr_o, exp_addr_q.pop_front());
         end
         if (obi_rvalid_i && inflight > 0) inflight--;
         if (inflight > max_inflight) max_inflight = inflight;
         if (push_o) begin
            n_push++;
            if (exp_data_q.size() > 0) chk("push_data", data_o, exp_data_q.pop_front());
            else chk("push_while_none_expected", push_o, 1'b0);
         end
         if (done_o) begin
            done_cnt++;
            done_cyc     = cyc;
            last_err     = err_o;
            busy_at_done = busy_o;
         end
         if (err_o) chk("err_o_without_done", done_o, 1'b1);
         prev_req  = obi_req_o;
         prev_gnt  = obi_gnt_i;
         prev_addr = obi_addr_o;
      end else begin
         prev_req = 1'b0;
      end
   end

   // Responder: answers each granted read, in order, one cycle after grant.
   initial begin
      logic [31:0] a;
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = 32'h0;
      obi_err_i    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rsp_en && pend_q.size() > 0) begin
            a            = pend_q.pop_front();
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = mem_word(a);
            obi_err_i    = err_addr_en && (a == err_addr);
         end else begin
            obi_rvalid_i = 1'b0;
            obi_rdata_i  = 32'h0;
            obi_err_i    = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [31:0] a, input int l);
      start    = 1'b1;
      src_addr = a;
      len      = 9'(l);
      step(1);
      start    = 1'b0;
   endtask

   // Queue the expected grant addresses (all beats) and pushed words (first ndata).
   task automatic start_xfer(input logic [31:0] a, input int l, input int ndata, output int sc);
      logic [31:0] base;
      base = a & ~32'h3;
      for (int k = 0; k < l; k++) exp_addr_q.push_back(base + 32'(k * 4));
      for (int k = 0; k < ndata; k++) exp_data_q.push_back(mem_word(base + 32'(k * 4)));
      first_gnt_cyc = -1;
      sc = cyc;
      pulse_start(a, l);
   endtask

   task automatic wait_done(input int d0, input int budget, input string tag);
      int k;
      k = 0;
      while (done_cnt == d0 && k < budget) begin
         step(1);
         k++;
      end
      chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'(1));
   endtask

   initial begin
      int sc, d0, np, g0;
      rst         = 1'b1;
      start       = 1'b0;
      src_addr    = 32'h0;
      len         = 9'd0;
      obi_gnt_i   = 1'b1;
      fifo_free_i = 3'd4;

      // Reset state
      step(3);
      @(negedge clk);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_req", obi_req_o, 1'b0);
      chk("rst_push", push_o, 1'b0);
      chk("rst_data", data_o, 32'h0);
      chk("rst_we", obi_we_o, 1'b0);
      chk("rst_be", obi_be_o, 4'hF);
      step(1);
      rst = 1'b0;
      step(1);

      // Basic 4-word transfer, everything always ready
      d0 = done_cnt; np = n_push;
      start_xfer(32'h0000_1000, 4, 4, sc);
      @(negedge clk);
      chk("basic_busy", busy_o, 1'b1);
      wait_done(d0, 30, "basic");
      chk("basic_first_req_latency", 64'(first_gnt_cyc - sc), 64'(1));
      chk("basic_done_cycle", 64'(done_cyc - sc), 64'(7));
      chk("basic_push_count", 64'(n_push - np), 64'(4));
      chk("basic_busy_at_done", busy_at_done, 1'b0);
      chk("basic_err", last_err, 1'b0);
      chk("basic_addr_left", 64'(exp_addr_q.size()), 64'(0));
      chk("basic_data_left", 64'(exp_data_q.size()), 64'(0));
      step(2);

      // Zero-length start
      d0 = done_cnt; g0 = n_grants;
      start_xfer(32'h0000_1200, 0, 0, sc);
      @(negedge clk);
      chk("len0_busy", busy_o, 1'b0);
      chk("len0_done", done_o, 1'b1);
      step(3);
      chk("len0_no_req", 64'(n_grants - g0), 64'(0));
      chk("len0_one_done", 64'(done_cnt - d0), 64'(1));
      chk("len0_done_cycle", 64'(done_cyc - sc), 64'(1));

      // One free FIFO slot: at most one beat in flight
      fifo_free_i = 3'd1;
      max_inflight = 0;
      d0 = done_cnt; np = n_push;
      start_xfer(32'h0000_2000, 3, 3, sc);
      wait_done(d0, 40, "free1");
      chk("free1_max_inflight", 64'(max_inflight), 64'(1));
      chk("free1_push_count", 64'(n_push - np), 64'(3));
      chk("free1_data_left", 64'(exp_data_q.size()), 64'(0));

      // No free space: request stalls until space returns
      fifo_free_i = 3'd0;
      d0 = done_cnt; g0 = n_grants;
      start_xfer(32'h0000_2100, 1, 1, sc);
      step(5);
      @(negedge clk);
      chk("stall_req_low", obi_req_o, 1'b0);
      chk("stall_no_grant", 64'(n_grants - g0), 64'(0));
      step(1);
      fifo_free_i = 3'd1;
      wait_done(d0, 20, "stall");
      chk("stall_data_left", 64'(exp_data_q.size()), 64'(0));
      step(1);

      // Grant withheld: req and addr hold; free dropping does not retract;
      // a start while busy is ignored
      fifo_free_i = 3'd4;
      obi_gnt_i   = 1'b0;
      d0 = done_cnt; np = n_push;
      start_xfer(32'h0000_3000, 2, 2, sc);
      @(negedge clk);
      chk("gntlow_req", obi_req_o, 1'b1);
      chk("gntlow_addr", obi_addr_o, 32'h0000_3000);
      step(1);
      fifo_free_i = 3'd0;
      pulse_start(32'h0000_9000, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gntlow_req_held", {obi_req_o, obi_addr_o}, {1'b1, 32'h0000_3000});
         step(1);
      end
      obi_gnt_i   = 1'b1;
      fifo_free_i = 3'd4;
      wait_done(d0, 30, "gntlow");
      chk("gntlow_push_count", 64'(n_push - np), 64'(2));
      chk("gntlow_addr_left", 64'(exp_addr_q.size()), 64'(0));
      chk("gntlow_data_left", 64'(exp_data_q.size()), 64'(0));
      step(1);

      // Address wrap at the top of the space
      d0 = done_cnt;
      start_xfer(32'hFFFF_FFF8, 3, 3, sc);
      wait_done(d0, 30, "wrap");
      chk("wrap_last_addr", last_gnt_addr, 32'h0000_0000);
      chk("wrap_addr_left", 64'(exp_addr_q.size()), 64'(0));
      chk("wrap_data_left", 64'(exp_data_q.size()), 64'(0));

      // Unaligned source address is word-aligned
      d0 = done_cnt;
      start_xfer(32'h0000_3003, 1, 1, sc);
      wait_done(d0, 20, "align");
      chk("align_addr", last_gnt_addr, 32'h0000_3000);
      chk("align_data_left", 64'(exp_data_q.size()), 64'(0));

      // Second beat of four returns an error
      err_addr    = 32'h0000_4004;
      err_addr_en = 1'b1;
      d0 = done_cnt; np = n_push;
`ifdef NDMA_RD_ERR_ABORT_EN
      start_xfer(32'h0000_4000, 4, 1, sc);
      wait_done(d0, 30, "errbeat");
      chk("errbeat_push_count", 64'(n_push - np), 64'(1));
      exp_addr_q.delete();
`else
      start_xfer(32'h0000_4000, 4, 4, sc);
      wait_done(d0, 30, "errbeat");
      chk("errbeat_push_count", 64'(n_push - np), 64'(4));
      chk("errbeat_addr_left", 64'(exp_addr_q.size()), 64'(0));
`endif
      chk("errbeat_err_o", last_err, 1'b1);
      chk("errbeat_data_left", 64'(exp_data_q.size()), 64'(0));
      err_addr_en = 1'b0;
      step(2);

      // Error flag cleared by the next start
      d0 = done_cnt;
      start_xfer(32'h0000_4100, 1, 1, sc);
      wait_done(d0, 20, "errclr");
      chk("errclr_err_o", last_err, 1'b0);

      // Reset with two reads outstanding; late responses must be dropped
      rsp_en = 1'b0;
      start_xfer(32'h0000_5000, 4, 0, sc);
      step(4);
      chk("rstmid_inflight", 64'(inflight), 64'(2));
      rst = 1'b1;
      step(1);
      @(negedge clk);
      chk("rstmid_busy", busy_o, 1'b0);
      chk("rstmid_req", obi_req_o, 1'b0);
      chk("rstmid_push", push_o, 1'b0);
      chk("rstmid_done", done_o, 1'b0);
      step(1);
      rst = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      inflight = 0;
      np = n_push; d0 = done_cnt;
      rsp_en = 1'b1;
      step(6);
      chk("rstmid_no_late_push", 64'(n_push - np), 64'(0));
      chk("rstmid_no_done", 64'(done_cnt - d0), 64'(0));

      // Normal operation after the abort
      d0 = done_cnt;
      start_xfer(32'h0000_6000, 2, 2, sc);
      wait_done(d0, 30, "recover");
      chk("recover_data_left", 64'(exp_data_q.size()), 64'(0));
      chk("recover_addr_left", 64'(exp_addr_q.size()), 64'(0));

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
